// File: rtl/led_pkg.sv
// Shared types and defaults for the LED pulse driver.
package led_pkg;

  // Per-channel stretcher state
  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StHold
  } ch_state_e;

  localparam int unsigned LED_STRETCH_DEFAULT  = 8;
  localparam int unsigned LED_PWM_BITS_DEFAULT = 4;

  // Width of a down-counter that must hold cycles-1
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/led_pulse_driver_if.sv
// LED request/drive bundle between the PIO side and the LED driver.
interface led_pulse_driver_if
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned PWM_BITS = LED_PWM_BITS_DEFAULT
);

  logic [NUM_LEDS-1:0] led_in;
  logic [PWM_BITS-1:0] brightness;
  logic                stretch_en;
  logic [NUM_LEDS-1:0] led_out;
  logic [NUM_LEDS-1:0] active;

  modport master (
    output led_in,
    output brightness,
    output stretch_en,
    input  led_out,
    input  active
  );

  modport slave (
    input  led_in,
    input  brightness,
    input  stretch_en,
    output led_out,
    output active
  );

endinterface

// File: rtl/led_stretch_ch.sv
// One LED channel: rising-edge pulse stretcher with level hold.
module led_stretch_ch
  import led_pkg::*;
#(
  parameter int unsigned STRETCH_CYCLES = LED_STRETCH_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic led_in,
  input  logic led_q,
  input  logic stretch_en,
  output logic lit
);

  localparam int unsigned    CntW    = cnt_width(STRETCH_CYCLES);
  localparam logic [CntW-1:0] CntLoad = CntW'(STRETCH_CYCLES - 1);

  ch_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rise;

  assign rise = led_in & ~led_q;

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: ON counts down the minimum lit time, HOLD follows a long level
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!stretch_en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rise) begin
            state_d = StOn;
            cnt_d   = CntLoad;
          end
        end
        StOn: begin
          if (rise) begin
            cnt_d = CntLoad;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
          end else if (led_in) begin
            state_d = StHold;
          end else begin
            state_d = StIdle;
          end
        end
        StHold: begin
          // A rise cannot occur here since led_in has been high since entry
          if (!led_in) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Bypass shows the delayed request so latency matches stretch mode
  assign lit = stretch_en ? (state_q != StIdle) : led_q;

endmodule

// File: rtl/led_pulse_driver.sv
// LED drive stage: per-channel pulse stretch, shared PWM dimming, registered pins.
module led_pulse_driver
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS       = 4,
  parameter int unsigned STRETCH_CYCLES = LED_STRETCH_DEFAULT,
  parameter int unsigned PWM_BITS       = LED_PWM_BITS_DEFAULT
) (
  input logic               clk,
  input logic               reset_n,
  led_pulse_driver_if.slave bus
);

  logic [NUM_LEDS-1:0] led_q;
  logic [NUM_LEDS-1:0] lit;
  logic [NUM_LEDS-1:0] led_out_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;

  // Request delay for edge detection, and free-running PWM counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q   <= '0;
      pwm_cnt <= '0;
    end else begin
      led_q   <= bus.led_in;
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_stretch_ch #(
      .STRETCH_CYCLES (STRETCH_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .led_in     (bus.led_in[i]),
      .led_q      (led_q[i]),
      .stretch_en (bus.stretch_en),
      .lit        (lit[i])
    );
  end

  // All-ones brightness forces full duty instead of (2^N-1)/2^N
  assign pwm_on = (&bus.brightness) | (pwm_cnt < bus.brightness);

  // Output register to the pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out_q <= '0;
    end else begin
      led_out_q <= lit & {NUM_LEDS{pwm_on}};
    end
  end

  assign bus.led_out = led_out_q;
  assign bus.active  = lit;

endmodule

// File: tb/tb_led_pulse_driver.sv
// Directed self-checking bench for led_pulse_driver.
module tb_led_pulse_driver;
  import led_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned SC = 8;
  localparam int unsigned PB = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  led_pulse_driver_if #(.NUM_LEDS(N), .PWM_BITS(PB)) bus ();

  led_pulse_driver #(
    .NUM_LEDS       (N),
    .STRETCH_CYCLES (SC),
    .PWM_BITS       (PB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Expected PWM phase, counted independently from reset release
  int pc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= 0;
    else          pc <= (pc + 1) % 16;
  end

  logic [3:0] stim  [0:63];
  logic [3:0] act_h [0:63];
  logic [3:0] out_h [0:63];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_stim();
    for (int k = 0; k < 64; k++) stim[k] = '0;
  endtask

  // Sample at each falling edge, then apply that slot's led_in
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      act_h[k]   = bus.active;
      out_h[k]   = bus.led_out;
      bus.led_in = stim[k];
    end
  endtask

  task automatic idle(input int n);
    bus.led_in = '0;
    repeat (n) @(negedge clk);
  endtask

  function automatic bit hist_bit(input int ch, input bit use_out, input int k);
    return use_out ? out_h[k][ch] : act_h[k][ch];
  endfunction

  function automatic int cnt_hi(input int ch, input bit use_out, input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (hist_bit(ch, use_out, k)) c++;
    return c;
  endfunction

  function automatic int first_hi(input int ch, input bit use_out, input int n);
    for (int k = 0; k < n; k++) if (hist_bit(ch, use_out, k)) return k;
    return -1;
  endfunction

  function automatic int last_hi(input int ch, input bit use_out, input int n);
    int l = -1;
    for (int k = 0; k < n; k++) if (hist_bit(ch, use_out, k)) l = k;
    return l;
  endfunction

  // active lit from exp_first for exp_len slots, led_out one slot later
  task automatic check_pulse(input string tag, input int ch, input int n,
                             input int exp_first, input int exp_len);
    check({tag, "_act_first"}, first_hi(ch, 1'b0, n), exp_first);
    check({tag, "_act_len"},   cnt_hi(ch, 1'b0, n), exp_len);
    check({tag, "_act_last"},  last_hi(ch, 1'b0, n), exp_first + exp_len - 1);
    check({tag, "_out_first"}, first_hi(ch, 1'b1, n), exp_first + 1);
    check({tag, "_out_len"},   cnt_hi(ch, 1'b1, n), exp_len);
    check({tag, "_out_last"},  last_hi(ch, 1'b1, n), exp_first + exp_len);
  endtask

  task automatic check_quiet(input string tag, input int ch, input int n);
    check({tag, "_act_quiet"}, cnt_hi(ch, 1'b0, n), 0);
    check({tag, "_out_quiet"}, cnt_hi(ch, 1'b1, n), 0);
  endtask

  initial begin
    int hits;
    bus.led_in     = '0;
    bus.brightness = 4'hF;
    bus.stretch_en = 1'b1;

    // Reset held, then released with idle input; PWM counter wraps
    repeat (3) @(negedge clk);
    check("rst_led_out", bus.led_out, 0);
    check("rst_active", bus.active, 0);
    check("rst_pwm_cnt", dut.pwm_cnt, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_led_out", bus.led_out, 0);
      check("idle_active", bus.active, 0);
      check("idle_pwm_cnt", dut.pwm_cnt, pc);
    end

    // Single-cycle pulse on channel 0
    clear_stim();
    stim[0] = 4'b0001;
    capture(16);
    check_pulse("t2_ch0", 0, 16, 1, SC);
    for (int c = 1; c < 4; c++) check_quiet($sformatf("t2_ch%0d", c), c, 16);
    idle(4);

    // 20-cycle level on channel 2
    clear_stim();
    for (int k = 0; k < 20; k++) stim[k] = 4'b0100;
    capture(26);
    check_pulse("t3_ch2", 2, 26, 1, 20);
    check_quiet("t3_ch0", 0, 26);
    idle(4);

    // Retrigger on channel 1
    clear_stim();
    stim[0] = 4'b0010;
    stim[5] = 4'b0010;
    capture(20);
    check_pulse("t4_retrig", 1, 20, 1, 13);
    idle(4);

    // Simultaneous pulses on all channels
    clear_stim();
    stim[0] = 4'hF;
    capture(14);
    for (int c = 0; c < 4; c++) check_pulse($sformatf("t4_all_ch%0d", c), c, 14, 1, SC);
    idle(4);

    // PWM with all channels held on
    bus.led_in = 4'hF;
    repeat (12) @(negedge clk);
    check("t5_hold_active", bus.active, 4'hF);
    bus.brightness = 4'd4;
    hits = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      // led_out reflects the PWM phase before the last rising edge
      check("t5_pwm4", bus.led_out, (((pc + 15) % 16) < 4) ? 4'hF : 4'h0);
      if (bus.led_out[0]) hits++;
    end
    check("t5_pwm4_duty", hits, 8);
    bus.brightness = 4'd0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("t5_pwm0_out", bus.led_out, 0);
      check("t5_pwm0_active", bus.active, 4'hF);
    end
    bus.brightness = 4'hF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("t5_pwm15_out", bus.led_out, 4'hF);
    end
    idle(12);
    check("t5_release", bus.active, 0);

    // Bypass: output follows a single-cycle pulse
    bus.stretch_en = 1'b0;
    idle(2);
    clear_stim();
    stim[0] = 4'b1000;
    capture(8);
    check_pulse("t6_bypass", 3, 8, 1, 1);

    // Reset mid-stretch clears immediately with no residual stretch
    bus.stretch_en = 1'b1;
    idle(2);
    clear_stim();
    stim[0] = 4'b1000;
    capture(4);
    check("t6_pre_rst_active", bus.active, 4'b1000);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_led_out", bus.led_out, 0);
    check("t6_rst_active", bus.active, 0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_stim();
    capture(12);
    check_quiet("t6_after_rst", 3, 12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
